cpu_step_ctrl: RTL and testbench

- Consumes single-cycle debounced button pulses (one clk wide, one per press) and produces the CPU clock-enable.
- Supports three modes: single step, continuous run at a divided rate, and fixed-length burst.
- Sits between the button pulse stages and the CPU core; also exports status for the display logic.

---
 rtl/cpu_step_ctrl.sv | 124 ++++++++++++
 tb/tb_cpu_step_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns debounced button pulses into the CPU clock-enable.
// Modes: single step, divided-rate continuous run, fixed-length burst.
module cpu_step_ctrl #(
    parameter int RUN_DIV   = 4,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_pulse,
    input  logic             run_pulse,
    input  logic             burst_pulse,
    input  logic             cpu_halt,
    output logic             cpu_en,
    output logic             running,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] step_count
);

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int BST_W = $clog2(BURST_LEN + 1);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(RUN_DIV - 1);
    localparam logic [BST_W-1:0] BST_INIT = BST_W'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STEP  = 2'd1,
        S_RUN   = 2'd2,
        S_BURST = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BST_W-1:0]   bst_q, bst_d;
    logic               en_q, en_d;
    logic               run_q, run_d;
    logic [CNT_W-1:0]   cnt_q;

    logic               div_hit;
    logic [DIV_W-1:0]   div_nxt;

    // Divider compare and wrap-around successor value.
    always_comb begin
        div_hit = (div_q == DIV_MAX);
        div_nxt = div_hit ? '0 : div_q + DIV_W'(1);
    end

    // Next-state, divider, burst count and the enable to be registered.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bst_d   = bst_q;
        en_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!cpu_halt) begin
                    if (run_pulse) begin
                        state_d = S_RUN;
                        div_d   = '0;
                    end else if (burst_pulse) begin
                        state_d = S_BURST;
                        div_d   = '0;
                        bst_d   = BST_INIT;
                    end else if (step_pulse) begin
                        state_d = S_STEP;
                        en_d    = 1'b1;
                    end
                end
            end
            S_STEP: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                if (cpu_halt || run_pulse) begin
                    state_d = S_IDLE;
                end else begin
                    div_d = div_nxt;
                    en_d  = div_hit;
                end
            end
            S_BURST: begin
                if (cpu_halt || run_pulse || bst_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    div_d = div_nxt;
                    if (div_hit) begin
                        en_d  = 1'b1;
                        bst_d = bst_q - BST_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        run_d = (state_d == S_RUN) || (state_d == S_BURST);
    end

    // State and registered outputs; synchronous reset aborts everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bst_q   <= '0;
            en_q    <= 1'b0;
            run_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bst_q   <= bst_d;
            en_q    <= en_d;
            run_q   <= run_d;
            cnt_q   <= cnt_q + CNT_W'(en_d);
        end
    end

    assign cpu_en     = en_q;
    assign running    = run_q;
    assign mode       = state_q;
    assign step_count = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed vector table plus multi-cycle sequences.
// A second instance covers RUN_DIV=1, short bursts and a narrow counter.
module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        step_pulse = 1'b0;
    logic        run_pulse = 1'b0;
    logic        burst_pulse = 1'b0;
    logic        cpu_halt = 1'b0;
    logic        cpu_en;
    logic        running;
    logic [1:0]  mode;
    logic [15:0] step_count;

    logic        s2_step = 1'b0;
    logic        s2_run = 1'b0;
    logic        s2_burst = 1'b0;
    logic        s2_halt = 1'b0;
    logic        s2_en;
    logic        s2_running;
    logic [1:0]  s2_mode;
    logic [3:0]  s2_count;

    int n_chk = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cpu_step_ctrl #(
        .RUN_DIV(4), .BURST_LEN(16), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .step_pulse(step_pulse), .run_pulse(run_pulse),
        .burst_pulse(burst_pulse), .cpu_halt(cpu_halt),
        .cpu_en(cpu_en), .running(running),
        .mode(mode), .step_count(step_count)
    );

    cpu_step_ctrl #(
        .RUN_DIV(1), .BURST_LEN(3), .CNT_W(4)
    ) dut2 (
        .clk(clk), .rst(rst),
        .step_pulse(s2_step), .run_pulse(s2_run),
        .burst_pulse(s2_burst), .cpu_halt(s2_halt),
        .cpu_en(s2_en), .running(s2_running),
        .mode(s2_mode), .step_count(s2_count)
    );

    typedef struct {
        logic        step;
        logic        run;
        logic        burst;
        logic        halt;
        logic        en;
        logic        running;
        logic [1:0]  mode;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(int s, int r, int b, int h,
                                int e, int rn, int m, int c);
        vec_t v;
        v.step    = (s != 0);
        v.run     = (r != 0);
        v.burst   = (b != 0);
        v.halt    = (h != 0);
        v.en      = (e != 0);
        v.running = (rn != 0);
        v.mode    = 2'(m);
        v.cnt     = 16'(c);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int wrong;
        int exit_c;
        bit done;

        //            s r b h  en run mode cnt
        vecs[0]  = mk(0,0,0,0, 0,0,0,0);
        vecs[1]  = mk(1,0,0,0, 1,0,1,1);
        vecs[2]  = mk(0,0,0,0, 0,0,0,1);
        vecs[3]  = mk(1,0,0,1, 0,0,0,1);
        vecs[4]  = mk(0,0,1,1, 0,0,0,1);
        vecs[5]  = mk(1,0,0,0, 1,0,1,2);
        vecs[6]  = mk(1,0,0,0, 0,0,0,2);
        vecs[7]  = mk(0,0,0,0, 0,0,0,2);
        vecs[8]  = mk(1,1,0,0, 0,1,2,2);
        vecs[9]  = mk(0,0,0,0, 0,1,2,2);
        vecs[10] = mk(0,0,0,0, 0,1,2,2);
        vecs[11] = mk(0,0,0,0, 0,1,2,2);
        vecs[12] = mk(0,0,0,0, 1,1,2,3);
        vecs[13] = mk(0,1,0,0, 0,0,0,3);
        vecs[14] = mk(0,1,1,0, 0,1,2,3);
        vecs[15] = mk(0,0,0,0, 0,1,2,3);
        vecs[16] = mk(0,0,0,0, 0,1,2,3);
        vecs[17] = mk(0,0,0,0, 0,1,2,3);
        vecs[18] = mk(0,1,0,0, 0,0,0,3);
        vecs[19] = mk(1,0,1,0, 0,1,3,3);
        vecs[20] = mk(0,0,0,0, 0,1,3,3);
        vecs[21] = mk(0,0,0,0, 0,1,3,3);
        vecs[22] = mk(0,0,0,0, 0,1,3,3);
        vecs[23] = mk(0,0,0,0, 1,1,3,4);
        vecs[24] = mk(0,0,0,1, 0,0,0,4);

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_en", cpu_en, 0);
        check("rst_running", running, 0);
        check("rst_mode", mode, 0);
        check("rst_count", step_count, 0);
        check("rst2_count", s2_count, 0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            step_pulse  = vecs[i].step;
            run_pulse   = vecs[i].run;
            burst_pulse = vecs[i].burst;
            cpu_halt    = vecs[i].halt;
            tick();
            check($sformatf("v%0d_en", i), cpu_en, vecs[i].en);
            check($sformatf("v%0d_running", i), running, vecs[i].running);
            check($sformatf("v%0d_mode", i), mode, vecs[i].mode);
            check($sformatf("v%0d_count", i), step_count, vecs[i].cnt);
        end
        step_pulse = 1'b0;
        run_pulse = 1'b0;
        burst_pulse = 1'b0;
        cpu_halt = 1'b0;
        exp_cnt = 4;

        // Run for 20 cycles then stop
        run_pulse = 1'b1;
        tick();
        run_pulse = 1'b0;
        check("run_entry_mode", mode, 2);
        pulses = 0;
        wrong = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (cpu_en) begin
                pulses++;
                if (c % 4 != 0) wrong++;
            end
        end
        run_pulse = 1'b1;
        tick();
        run_pulse = 1'b0;
        exp_cnt += 5;
        check("run_pulses", pulses, 5);
        check("run_spacing", wrong, 0);
        check("run_exit_running", running, 0);
        check("run_exit_en", cpu_en, 0);
        check("run_count", step_count, exp_cnt);

        // Burst of 16 with a retrigger attempt mid-burst
        burst_pulse = 1'b1;
        tick();
        burst_pulse = 1'b0;
        check("burst_entry_mode", mode, 3);
        pulses = 0;
        wrong = 0;
        done = 0;
        exit_c = 0;
        for (int c = 1; c <= 200 && !done; c++) begin
            if (c == 30) begin
                burst_pulse = 1'b1;
                step_pulse = 1'b1;
            end
            tick();
            burst_pulse = 1'b0;
            step_pulse = 1'b0;
            if (cpu_en) begin
                pulses++;
                if (c % 4 != 0) wrong++;
            end
            if (mode == 2'd0) begin
                done = 1;
                exit_c = c;
            end
        end
        exp_cnt += 16;
        check("burst_done", done, 1);
        check("burst_pulses", pulses, 16);
        check("burst_spacing", wrong, 0);
        check("burst_exit_cycle", exit_c, 65);
        check("burst_count", step_count, exp_cnt);

        // Halt during run after 3 pulses
        run_pulse = 1'b1;
        tick();
        run_pulse = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 40 && pulses < 3; c++) begin
            tick();
            if (cpu_en) pulses++;
        end
        check("halt_pre_pulses", pulses, 3);
        cpu_halt = 1'b1;
        tick();
        check("halt_mode", mode, 0);
        check("halt_running", running, 0);
        check("halt_en", cpu_en, 0);
        pulses = 0;
        step_pulse = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            step_pulse = 1'b0;
            if (cpu_en) pulses++;
        end
        check("halt_step_ignored", pulses, 0);
        check("halt_idle_mode", mode, 0);
        cpu_halt = 1'b0;
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        check("post_halt_step_en", cpu_en, 1);
        check("post_halt_step_mode", mode, 1);
        tick();
        check("post_halt_step_off", cpu_en, 0);
        check("post_halt_mode", mode, 0);
        exp_cnt += 4;
        check("halt_count", step_count, exp_cnt);

        // Reset in the middle of a burst after 5 pulses
        burst_pulse = 1'b1;
        tick();
        burst_pulse = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 100 && pulses < 5; c++) begin
            tick();
            if (cpu_en) pulses++;
        end
        check("mid_burst_pulses", pulses, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        check("mid_rst_en", cpu_en, 0);
        check("mid_rst_running", running, 0);
        check("mid_rst_mode", mode, 0);
        check("mid_rst_count", step_count, exp_cnt);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (cpu_en) pulses++;
        end
        check("mid_rst_no_resume", pulses, 0);
        check("mid_rst_stay_idle", mode, 0);

        // Narrow counter wraps after 17 steps
        pulses = 0;
        for (int k = 0; k < 17; k++) begin
            s2_step = 1'b1;
            tick();
            s2_step = 1'b0;
            if (s2_en) pulses++;
            tick();
        end
        check("wrap_pulses", pulses, 17);
        check("wrap_count", s2_count, 1);

        // RUN_DIV=1: enable high every cycle after entry
        s2_run = 1'b1;
        tick();
        s2_run = 1'b0;
        check("div1_entry_en", s2_en, 0);
        check("div1_entry_mode", s2_mode, 2);
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (s2_en) pulses++;
        end
        check("div1_pulses", pulses, 10);
        s2_run = 1'b1;
        tick();
        s2_run = 1'b0;
        check("div1_exit_en", s2_en, 0);
        check("div1_exit_mode", s2_mode, 0);
        check("div1_count", s2_count, 11);

        // Short burst at RUN_DIV=1
        s2_burst = 1'b1;
        tick();
        s2_burst = 1'b0;
        check("b3_entry_mode", s2_mode, 3);
        pulses = 0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (s2_en && s2_mode == 2'd3) pulses++;
        end
        check("b3_pulses", pulses, 3);
        tick();
        check("b3_exit_en", s2_en, 0);
        check("b3_exit_mode", s2_mode, 0);
        check("b3_exit_running", s2_running, 0);
        check("b3_count", s2_count, 14);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
